// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I multicycle control block.
// Holds the controller state encoding, the major opcodes it dispatches on,
// the datapath mux encodings and the ALU operation codes.
package rv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JALR_ADR,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // How the ALU operation is chosen in a given state.
    typedef enum logic [1:0] {
        ALU_MODE_ADD,
        ALU_MODE_SUB,
        ALU_MODE_FUNCT
    } alu_mode_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

endpackage

// File: rtl/rv_alu_dec.sv
// ALU decoder: maps the controller's ALU mode plus the instruction's
// funct3/funct7b5 to an ALU operation code.
// Ports:
//   alu_mode  in   add / sub / decode-from-funct
//   funct3    in   IR[14:12]
//   funct7b5  in   IR[30]
//   is_rtype  in   1 for register-register ops (enables SUB on funct3=000)
//   alu_ctl   out  ALU operation code
module rv_alu_dec
    import rv_pkg::*;
(
    input  alu_mode_t   alu_mode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        is_rtype,
    output logic [3:0]  alu_ctl
);

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the case statements can infer a latch.
    always_comb begin
        alu_ctl = ALU_ADD;
        case (alu_mode)
            ALU_MODE_SUB: alu_ctl = ALU_SUB;
            ALU_MODE_FUNCT: begin
                case (funct3)
                    3'b000:  alu_ctl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctl = ALU_SLL;
                    3'b010:  alu_ctl = ALU_SLT;
                    3'b011:  alu_ctl = ALU_SLTU;
                    3'b100:  alu_ctl = ALU_XOR;
                    // funct7b5 distinguishes arithmetic from logical right shift
                    // for both register and immediate forms.
                    3'b101:  alu_ctl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctl = ALU_OR;
                    default: alu_ctl = ALU_AND;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multicycle control FSM for the RV32I structural core. Sequences the shared
// PC/OldPC/IR registers, register file, single ALU and unified memory port,
// one control word per cycle, stalling on the memory handshake.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   opcode/funct3/funct7b5   instruction fields from IR
//   branch_taken             branch comparator result
//   mem_ready                memory completes current request this cycle
//   mem_req/mem_we/adr_src   memory port control
//   ir_we/pc_we/reg_we       register write enables
//   alu_src_a/alu_src_b      ALU operand selects
//   result_src               result mux select
//   alu_ctl                  ALU operation code
//   trap                     illegal opcode seen (sticky until rst)
module rv_mc_ctrl
    import rv_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [3:0]  alu_ctl,
    output logic        trap
);

    state_t     state;
    state_t     state_next;
    alu_mode_t  alu_mode;
    logic       alu_is_rtype;
    logic [3:0] alu_ctl_dec;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= RESET_STATE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        adr_src      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        reg_we       = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        result_src   = RES_ALUOUT;
        alu_mode     = ALU_MODE_ADD;
        alu_is_rtype = 1'b0;
        trap         = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // OldPC+imm parks the branch/JAL target in ALUOut.
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE:         state_next = S_MEMADR;
                    OP_R:                      state_next = S_EXEC_R;
                    OP_I, OP_LUI, OP_AUIPC:    state_next = S_EXEC_I;
                    OP_BRANCH:                 state_next = S_BRANCH;
                    OP_JAL:                    state_next = S_JAL;
                    OP_JALR:                   state_next = S_JALR_ADR;
                    default:                   state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                result_src = RES_MEM;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a    = SRC_A_RS1;
                alu_src_b    = SRC_B_RS2;
                alu_mode     = ALU_MODE_FUNCT;
                alu_is_rtype = 1'b1;
                state_next   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_b = SRC_B_IMM;
                // LUI adds imm to zero, AUIPC to OldPC; both force ADD.
                if (opcode == OP_LUI) begin
                    alu_src_a = SRC_A_ZERO;
                end else if (opcode == OP_AUIPC) begin
                    alu_src_a = SRC_A_OLDPC;
                end else begin
                    alu_src_a = SRC_A_RS1;
                    alu_mode  = ALU_MODE_FUNCT;
                end
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we     = 1'b1;
                result_src = RES_ALUOUT;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_mode   = ALU_MODE_SUB;
                pc_we      = branch_taken;
                result_src = RES_ALUOUT;
                state_next = S_FETCH;
            end
            S_JALR_ADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                state_next = S_JAL;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms the link.
                pc_we      = 1'b1;
                result_src = RES_ALUOUT;
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                state_next = S_ALUWB;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase

        // Reset silences the outputs in the same cycle it is asserted, which
        // abandons any in-flight memory request before the state register
        // has moved.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            adr_src    = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            reg_we     = 1'b0;
            alu_src_a  = '0;
            alu_src_b  = '0;
            result_src = '0;
            trap       = 1'b0;
        end
    end

    rv_alu_dec u_alu_dec (
        .alu_mode (alu_mode),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .is_rtype (alu_is_rtype),
        .alu_ctl  (alu_ctl_dec)
    );

    assign alu_ctl = rst ? 4'b0000 : alu_ctl_dec;

endmodule

// File: doc/rv_mc_ctrl.md
# rv_mc_ctrl

Multicycle control FSM for the RV32I structural core. It sequences the shared datapath: PC/OldPC/IR registers, register file, the single ALU, the unified instruction/data memory port and the immediate generator. The immediate generator selects its format from the opcode, so this block issues no immediate-select. It decodes the IR opcode/funct fields, drives one control word per cycle, and stalls on the memory handshake.

## Interface
Parameters
- `RESET_STATE`, `S_FETCH`: state entered on reset.

Ports
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `opcode`  in  7  IR[6:0].
- `funct3`  in  3  IR[14:12].
- `funct7b5`  in  1  IR[30].
- `branch_taken`  in  1  branch comparator result for funct3 (beq/bne/blt/bge/bltu/bgeu).
- `mem_ready`  in  1  memory completes current request this cycle.
- `mem_req`  out  1  memory request; held until `mem_ready`.
- `mem_we`  out  1  store qualifier, valid with `mem_req`.
- `adr_src`  out  1  0 = PC, 1 = ALUOut.
- `ir_we`  out  1  load IR and OldPC.
- `pc_we`  out  1  load PC from result mux.
- `reg_we`  out  1  register-file write.
- `alu_src_a`  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- `alu_src_b`  out  2  00 rs2, 01 imm, 10 const 4.
- `result_src`  out  2  00 ALUOut, 01 mem data, 10 ALU result.
- `alu_ctl`  out  4  ALU operation code.
- `trap`  out  1  illegal opcode seen; sticky.

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JALR_ADR, JAL, TRAP.
- FETCH: `mem_req`=1, `adr_src`=0, ALU = PC+4 (src_a 00, src_b 10, result_src 10). Stays while `mem_ready`=0. When `mem_ready`=1: `ir_we`=1, `pc_we`=1, go to DECODE.
- DECODE: ALU = OldPC+imm, so ALUOut holds the branch/JAL target. Dispatch on opcode:
  - 0000011 / 0100011 → MEMADR.
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 0110111 (LUI) → EXEC_I with src_a = zero.
  - 0010111 (AUIPC) → EXEC_I with src_a = OldPC.
  - 1100011 → BRANCH.
  - 1101111 → JAL.
  - 1100111 → JALR_ADR.
  - Any other opcode → TRAP.
- MEMADR: ALU = rs1+imm. Load → MEMREAD; store → MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1; wait for `mem_ready`, then MEMWB.
- MEMWB: `reg_we`=1, result_src 01; then FETCH.
- MEMWRITE: `mem_req`=1, `mem_we`=1, `adr_src`=1; wait for `mem_ready`, then FETCH.
- EXEC_R: src_a rs1, src_b rs2; `alu_ctl` from funct3/funct7b5; then ALUWB.
- EXEC_I: src_b imm. `alu_ctl` from funct3; funct7b5 is used only for srli/srai. LUI/AUIPC force ADD. Then ALUWB.
- ALUWB: `reg_we`=1, result_src 00; then FETCH.
- BRANCH: ALU = rs1 − rs2 (SUB). `pc_we`=`branch_taken`, result_src 00 (target). Then FETCH.
- JALR_ADR: ALU = rs1+imm; then JAL.
- JAL: `pc_we`=1 from ALUOut (target). ALU = OldPC+4. Then ALUWB, which writes the link value.
- TRAP: all enables 0, `trap`=1. Held until `rst`.
- `alu_ctl` is ADD in every state not listed above.
- All write enables and `mem_req` are Moore outputs of the state. Exceptions: `ir_we`/`pc_we` in FETCH and `pc_we` in BRANCH are also gated by the named inputs.

## Timing
- Reset: state = FETCH next edge. While `rst`=1 every output is 0, including `mem_req`. An in-flight memory request is abandoned. `trap` clears.
- Cycles per instruction, zero-wait memory: R/I/LUI/AUIPC 4; load 5; store 4; branch 3; JAL 4; JALR 5.
- Each cycle `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- While stalled, `mem_req`, `mem_we`, `adr_src` and the ALU controls stay constant.
- `mem_ready` is ignored outside FETCH/MEMREAD/MEMWRITE.
- `rst` has priority over a same-cycle `mem_ready`.

## Structure
- Shared package `rv_pkg`: state enum, opcode localparams, `alu_src_a`/`alu_src_b`/`result_src` encodings, `alu_ctl` codes.
- Sub-module `rv_alu_dec`: combinational map of (alu_mode add/sub/funct, funct3, funct7b5, is_rtype) → `alu_ctl`.

## Test plan
- ADDI 0x00500093, `mem_ready` always 1 → FETCH, DECODE, EXEC_I, ALUWB. `reg_we` high only in cycle 4; `alu_ctl`=ADD; src_b=imm.
- LW 0x00812283 with `mem_ready` low 2 cycles in MEMREAD → 7 cycles total; `mem_req`/`adr_src`=1 stable during the stall; `reg_we` with result_src 01 once.
- BEQ 0x00208863 → with `branch_taken`=1, `pc_we` asserts in BRANCH with result_src 00. With `branch_taken`=0, `pc_we` stays 0. Both cases take 3 cycles.
- JALR 0x000080E7 → JALR_ADR, JAL (`pc_we`=1), ALUWB (`reg_we`=1); 5 cycles.
- Opcode 0x0000007F → TRAP after DECODE; `trap`=1 persists for 10 cycles, then `rst` → outputs 0 and FETCH.
- `rst` asserted mid-MEMWRITE with `mem_ready`=1 the same cycle → `mem_req`/`mem_we` drop at once; next state FETCH; no `pc_we`.
